bram_fifo: RTL

Synchronous single-clock FIFO built on an inferred synchronous dual-port block RAM. It buffers a producer stream and hands it to a consumer with registered full/empty/count flags. Write traffic uses memory port A and read traffic uses port B. It sits directly upstream of any consumer that pulls data with a read strobe, such as a UART transmitter or a DMA drain.

---
 rtl/bram_fifo_pkg.sv | 12 +
 rtl/bram_fifo_ptr_ctrl.sv | 97 +++++++++
 rtl/bram_fifo.sv | 72 +++++++
 3 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared defaults and helpers for the block-RAM FIFO.
// Optional almost-full/almost-empty flags are enabled by BRAM_FIFO_ALMOST_FLAGS_EN.
package bram_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/bram_fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for bram_fifo; all outputs except the accept strobes are registered.
// Almost-full/almost-empty flags exist only when BRAM_FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ptr_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  , parameter int AF_LEVEL = depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL = 1
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_ok,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  , output logic                almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] r_w_ptr;
  logic [ADDR_WIDTH-1:0] r_r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // A write into a full FIFO is legal when a read frees the slot on the same edge.
  always_comb begin
    w_rd_ok      = rd & ~r_empty;
    w_wr_ok      = wr & (~r_full | w_rd_ok);
    w_count_next = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + (ADDR_WIDTH+1)'(1);
      2'b01:   w_count_next = r_count - (ADDR_WIDTH+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_ok) r_w_ptr <= r_w_ptr + (ADDR_WIDTH)'(1);
      if (w_rd_ok) r_r_ptr <= r_r_ptr + (ADDR_WIDTH)'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == L_DEPTH);
      r_empty <= (w_count_next == '0);
    end
  end

`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] L_AF = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] L_AE = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_next >= L_AF);
      r_almost_empty <= (w_count_next <= L_AE);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

  assign wr_ok = w_wr_ok;
  assign rd_ok = w_rd_ok;
  assign w_ptr = r_w_ptr;
  assign r_ptr = r_r_ptr;
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/bram_fifo.sv
// Single-clock FIFO over an inferred read-first dual-port block RAM (port A writes, port B reads).
// Define BRAM_FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty and their thresholds.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  , parameter int AF_LEVEL = depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL = 1
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  , output logic                almost_full,
  output logic                  almost_empty
`endif
);

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_w_ptr;
  logic [ADDR_WIDTH-1:0] w_r_ptr;
  logic [DATA_WIDTH-1:0] r_mem [depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] r_rdata;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    , .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
`endif
  ) u_ptr_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .wr_ok        (w_wr_ok),
    .rd_ok        (w_rd_ok),
    .w_ptr        (w_w_ptr),
    .r_ptr        (w_r_ptr),
    .full         (full),
    .empty        (empty),
    .count        (count)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    , .almost_full (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Port A: memory is not cleared by reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_w_ptr] <= w_data;
  end

  // Port B: read-first, so a full-FIFO write+read at the same address returns the old word.
  always_ff @(posedge clk) begin
    if (reset)        r_rdata <= '0;
    else if (w_rd_ok) r_rdata <= r_mem[w_r_ptr];
  end

  assign r_data = r_rdata;

endmodule
